// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction-fetch path.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

    // One buffered fetch result: instruction word plus the PC it was read from.
    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Force a PC onto a word boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with first-word fall-through and a single-cycle flush.
// Storage is a plain register array: the head has to be readable combinationally
// in the same cycle it becomes valid, which a registered-read RAM cannot offer.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;
    logic [DEPTH-1:0] wr_en;

    // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
    // when a pop frees the slot in the same cycle.
    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);

    // One write strobe per storage slot, selected by the write pointer.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_wr_en
            assign wr_en[gi] = do_push && !flush && (wr_ptr_reg == AW'(gi));
        end
    endgenerate

    // Data slots carry no reset: validity is tracked entirely by count_reg.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem_reg[i] <= push_data;
            end
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the FIFO outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign empty     = (count_reg == '0);
    assign count     = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues in-order word reads, buffers the returned
// words with their PC and presents them to the decoder over valid/ready.
// A redirect flushes the buffer and marks every in-flight read as stale.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instruction,
    output logic [XLEN-1:0] instr_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] pc_reg,          pc_next;
    logic [XLEN-1:0] rsp_pc_reg,      rsp_pc_next;
    logic [CW-1:0]   outstanding_reg, outstanding_next;
    logic [CW-1:0]   drop_cnt_reg,    drop_cnt_next;
    logic            running_reg;

    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    fetch_entry_t    fifo_head;
    fetch_entry_t    push_entry;
    logic [CW:0]     credit_used;
    logic            req_hs;
    logic            rsp_keep;
    logic            rsp_drop;
    logic            pop;

    // Every buffered word plus every read in flight consumes one FIFO slot, so
    // the FIFO can never be overrun by responses. running_reg keeps requests
    // quiet while reset is held and for the release cycle.
    assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding_reg};
    assign imem_req_valid = running_reg && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc_reg;
    assign req_hs         = imem_req_valid && imem_req_ready;

    // Responses are kept only when no stale reads are pending and no redirect
    // is flushing the stage this cycle.
    assign rsp_keep   = imem_rsp_valid && (drop_cnt_reg == '0) && !redirect_valid;
    assign rsp_drop   = imem_rsp_valid && (drop_cnt_reg != '0);
    assign pop        = instr_valid && instr_ready;
    assign push_entry = '{instr: imem_rsp_data, pc: rsp_pc_reg};

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Next values for PC, response PC and the in-flight counters.
    always_comb begin
        pc_next          = pc_reg;
        rsp_pc_next      = rsp_pc_reg;
        drop_cnt_next    = drop_cnt_reg;
        outstanding_next = outstanding_reg + CW'(req_hs) - CW'(imem_rsp_valid);

        if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the old
            // path, including a request accepted right now.
            pc_next       = align_pc(redirect_pc);
            rsp_pc_next   = align_pc(redirect_pc);
            drop_cnt_next = outstanding_next;
        end else begin
            if (req_hs) begin
                pc_next = pc_reg + PC_STEP;
            end
            if (rsp_keep) begin
                rsp_pc_next = rsp_pc_reg + PC_STEP;
            end
            if (rsp_drop) begin
                drop_cnt_next = drop_cnt_reg - 1'b1;
            end
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg          <= RESET_PC;
            rsp_pc_reg      <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            running_reg     <= 1'b0;
        end else begin
            pc_reg          <= pc_next;
            rsp_pc_reg      <= rsp_pc_next;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
            running_reg     <= 1'b1;
        end
    end

    // Present the FIFO head; show a NOP at the reset PC while nothing is buffered.
    always_comb begin
        instr_valid = !fifo_empty;
        instruction = NOP_INSTR;
        instr_pc    = RESET_PC;
        if (!fifo_empty) begin
            instruction = fifo_head.instr;
            instr_pc    = fifo_head.pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a behavioural instruction memory, a scoreboard of
// expected {instruction, pc} pairs, and one task per scenario.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;

    // Second instance for the wrap-around reset PC.
    logic        rst2_n = 1'b1;
    logic        req2_valid;
    logic [31:0] req2_addr;
    logic        instr2_valid;
    logic [31:0] instr2;
    logic [31:0] instr2_pc;

    int compares = 0;
    int fails    = 0;
    int cyc      = 0;
    int pops     = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
    } pend_t;

    pend_t       pend_q[$];
    logic [63:0] sb_q[$];
    logic [63:0] exp_e;
    logic [31:0] model_pc = 32'h0;
    int          lat = 1;
    bit          imem_rand = 1'b0;
    bit          dec_en = 1'b1;
    bit          dec_rand = 1'b0;
    bit          redir_hs = 1'b0;
    bit          redir_rsp = 1'b0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) u_dut_wrap (
        .clk            (clk),
        .rst_n          (rst2_n),
        .imem_req_valid (req2_valid),
        .imem_req_ready (1'b1),
        .imem_req_addr  (req2_addr),
        .imem_rsp_valid (1'b0),
        .imem_rsp_data  (32'h0),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .instr_valid    (instr2_valid),
        .instr_ready    (1'b1),
        .instruction    (instr2),
        .instr_pc       (instr2_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
    endfunction

    // Memory model, decoder model and scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            pend_q.delete();
            sb_q.delete();
            model_pc       = 32'h0;
            imem_rsp_valid = 1'b0;
            imem_req_ready = 1'b0;
            instr_ready    = 1'b0;
        end else begin
            imem_req_ready = imem_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            instr_ready    = dec_en && (dec_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
            if (pend_q.size() > 0 && pend_q[0].due <= 32'(cyc)) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_q[0].addr);
                void'(pend_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
            if (imem_req_valid && imem_req_ready) begin
                compares++;
                if (imem_req_addr !== model_pc) begin
                    fails++;
                    $display("FAIL req_addr: got %h expected %h (cycle %0d)", imem_req_addr, model_pc, cyc);
                end
                pend_q.push_back({imem_req_addr, 32'(cyc + lat)});
                sb_q.push_back({mem_word(model_pc), model_pc});
                model_pc += 32'd4;
            end
            if (instr_valid && instr_ready) begin
                pops++;
                compares++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL instr_unexpected: got instr %h pc %h expected none", instruction, instr_pc);
                end else begin
                    exp_e = sb_q.pop_front();
                    if ({instruction, instr_pc} !== exp_e) begin
                        fails++;
                        $display("FAIL instr_out: got instr %h pc %h expected instr %h pc %h",
                                 instruction, instr_pc, exp_e[63:32], exp_e[31:0]);
                    end else begin
                        $display("instr pc=%h data=%h ok", instr_pc, instruction);
                    end
                end
            end
            if (redirect_valid) begin
                redir_hs  = imem_req_valid && imem_req_ready;
                redir_rsp = imem_rsp_valid;
                sb_q.delete();
                model_pc = redirect_pc & ~32'h3;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_valid(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step(1);
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        step(2);
        compares += 5;
        if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
        if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_instr_valid: got %b expected 0", instr_valid); end
        if (instruction !== 32'h0000_0013) begin fails++; $display("FAIL rst_instruction: got %h expected 00000013", instruction); end
        if (instr_pc !== 32'h0) begin fails++; $display("FAIL rst_instr_pc: got %h expected 00000000", instr_pc); end
        if (imem_req_addr !== 32'h0) begin fails++; $display("FAIL rst_req_addr: got %h expected 00000000", imem_req_addr); end
        rst_n = 1'b1;
        step(1);
        compares++;
        if (imem_req_valid !== 1'b1) begin fails++; $display("FAIL first_req: got %b expected 1", imem_req_valid); end
        $display("test_reset done");
    endtask

    task automatic test_stream();
        bit ok;
        int vcnt;
        lat = 1;
        wait_valid(20, ok);
        compares++;
        if (!ok || instr_pc !== 32'h0) begin fails++; $display("FAIL stream_first: got valid %b pc %h expected valid 1 pc 00000000", ok, instr_pc); end
        step(4);
        vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (instr_valid) vcnt++;
            step(1);
        end
        compares++;
        if (vcnt != 12) begin fails++; $display("FAIL back_to_back: got %0d valid cycles expected 12", vcnt); end
        $display("test_stream done");
    endtask

    task automatic test_stall();
        logic [31:0] head_pc;
        logic [31:0] head_ins;
        int          pops0;
        dec_en = 1'b0;
        step(1);
        head_pc  = instr_pc;
        head_ins = instruction;
        step(9);
        compares += 4;
        if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL stall_req_valid: got %b expected 0", imem_req_valid); end
        if (sb_q.size() != DEPTH) begin fails++; $display("FAIL stall_inflight: got %0d expected %0d", sb_q.size(), DEPTH); end
        if (instr_valid !== 1'b1) begin fails++; $display("FAIL stall_valid: got %b expected 1", instr_valid); end
        if (instr_pc !== head_pc || instruction !== head_ins) begin
            fails++;
            $display("FAIL stall_head: got pc %h instr %h expected pc %h instr %h", instr_pc, instruction, head_pc, head_ins);
        end
        pops0  = pops;
        dec_en = 1'b1;
        step(15);
        compares++;
        if (pops - pops0 < DEPTH) begin fails++; $display("FAIL stall_drain: got %0d pops expected >= %0d", pops - pops0, DEPTH); end
        $display("test_stall done");
    endtask

    task automatic test_redirect();
        bit ok;
        lat = 3;
        step(10);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (pend_q.size() == 3) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        compares++;
        if (!ok) begin fails++; $display("FAIL redir_setup: got outstanding %0d expected 3", pend_q.size()); end
        pulse_redirect(32'h0000_0102);
        compares += 2;
        if (instr_valid !== 1'b0) begin fails++; $display("FAIL redir_flush: got %b expected 0", instr_valid); end
        if (imem_req_addr !== 32'h100) begin fails++; $display("FAIL redir_addr: got %h expected 00000100", imem_req_addr); end
        wait_valid(30, ok);
        compares++;
        if (!ok || instr_pc !== 32'h100 || instruction !== mem_word(32'h100)) begin
            fails++;
            $display("FAIL redir_first: got valid %b pc %h instr %h expected pc 00000100 instr %h", ok, instr_pc, instruction, mem_word(32'h100));
        end
        step(10);
        $display("test_redirect done");
    endtask

    task automatic test_redirect_collide();
        bit ok;
        lat = 1;
        step(8);
        pulse_redirect(32'h0000_0200);
        compares++;
        if (!(redir_hs && redir_rsp)) begin fails++; $display("FAIL collide_cond: got hs %b rsp %b expected 1 1", redir_hs, redir_rsp); end
        wait_valid(20, ok);
        compares++;
        if (!ok || instr_pc !== 32'h200) begin fails++; $display("FAIL collide_first: got valid %b pc %h expected pc 00000200", ok, instr_pc); end
        step(10);
        $display("test_redirect_collide done");
    endtask

    task automatic test_redirect_twice();
        bit ok;
        lat = 3;
        step(8);
        pulse_redirect(32'h0000_0300);
        pulse_redirect(32'h0000_0407);
        wait_valid(30, ok);
        compares++;
        if (!ok || instr_pc !== 32'h404) begin fails++; $display("FAIL twice_first: got valid %b pc %h expected pc 00000404", ok, instr_pc); end
        step(10);
        $display("test_redirect_twice done");
    endtask

    task automatic test_random();
        int pops0;
        pops0     = pops;
        lat       = 2;
        imem_rand = 1'b1;
        dec_rand  = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if (i == 50 || i == 100) begin
                pulse_redirect($urandom & 32'h0000_FFFF);
            end else begin
                step(1);
            end
        end
        imem_rand = 1'b0;
        dec_rand  = 1'b0;
        step(20);
        compares++;
        if (pops - pops0 < 40) begin fails++; $display("FAIL random_progress: got %0d pops expected >= 40", pops - pops0); end
        $display("test_random done");
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [4];
        logic [31:0] got_a [4];
        int          n;
        exp_a[0] = 32'hFFFF_FFF8;
        exp_a[1] = 32'hFFFF_FFFC;
        exp_a[2] = 32'h0000_0000;
        exp_a[3] = 32'h0000_0004;
        rst2_n = 1'b1;
        n = 0;
        for (int i = 0; i < 12 && n < 4; i++) begin
            if (req2_valid) begin
                got_a[n] = req2_addr;
                n++;
            end
            step(1);
        end
        compares++;
        if (n != 4) begin fails++; $display("FAIL wrap_count: got %0d expected 4", n); end
        for (int i = 0; i < n; i++) begin
            compares++;
            if (got_a[i] !== exp_a[i]) begin fails++; $display("FAIL wrap_addr%0d: got %h expected %h", i, got_a[i], exp_a[i]); end
            else $display("wrap req addr=%h ok", got_a[i]);
        end
        compares++;
        if (req2_valid !== 1'b0) begin fails++; $display("FAIL wrap_credit: got %b expected 0", req2_valid); end
        $display("test_wrap done");
    endtask

    task automatic test_async_reset();
        bit ok;
        lat = 1;
        step(6);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        compares += 2;
        if (instr_valid !== 1'b0) begin fails++; $display("FAIL areset_instr_valid: got %b expected 0", instr_valid); end
        if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL areset_req_valid: got %b expected 0", imem_req_valid); end
        step(3);
        rst_n = 1'b1;
        wait_valid(20, ok);
        compares++;
        if (!ok || instr_pc !== 32'h0 || instruction !== mem_word(32'h0)) begin
            fails++;
            $display("FAIL areset_restart: got valid %b pc %h instr %h expected pc 00000000 instr %h", ok, instr_pc, instruction, mem_word(32'h0));
        end
        step(10);
        $display("test_async_reset done");
    endtask

    initial begin
        #1 rst2_n = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_collide();
        test_redirect_twice();
        test_random();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
